mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing one SOC memory target port: RAM, MappedSPIFlash or IO mux, each with rstrb/rbusy/wmask semantics.
- M0 is the Processor; M1 is a second requester, e.g. a DMA or UART loader.
- Each master's single-cycle requests are captured into a pending slot and issued one at a time, round-robin.
- Read data and completion are returned per master via that master's busy output.

Parameters:
ADDR_W, 32, width of addresses passed through (LSBs [1:0] forwarded unchanged)
M0_FIRST, 1, 1 = M0 wins the first contested grant after reset

Ports:
clk  input  1  system clock
resetn  input  1  synchronous, active-low reset
m0_addr  input  ADDR_W  M0 address
m0_rstrb  input  1  M0 read request pulse
m0_wdata  input  32  M0 write data
m0_wmask  input  4  M0 byte write mask (nonzero = write request pulse)
m0_rdata  output  32  M0 read data, valid when m0_busy low after a read
m0_busy  output  1  M0 transaction pending or in flight
m1_addr, m1_rstrb, m1_wdata, m1_wmask, m1_rdata, m1_busy: same as M0, for M1
t_addr  output  ADDR_W  target address
t_rstrb  output  1  target read strobe, one-cycle pulse
t_wdata  output  32  target write data
t_wmask  output  4  target write mask, one-cycle pulse
t_rdata  input  32  target read data
t_rbusy  input  1  target busy; data valid in first cycle at or after issue+1 with t_rbusy=0

Behaviour:
- Reset (resetn=0 at posedge):
  - Both slots empty; state IDLE.
  - All t_* and mN_* outputs 0: t_rstrb=0, t_wmask=0, t_addr=0, t_wdata=0, mN_rdata=0, mN_busy=0.
  - last_grant = M0_FIRST ? M1 : M0.
  - Reset mid-transaction abandons the outstanding target access; no data is delivered.
- Capture:
  - Master request at edge T (rstrb=1 or wmask!=0) with its slot empty: slot loads addr, wdata, wmask, is_write=(wmask!=0).
  - rstrb together with nonzero wmask is a write; the read is dropped.
  - Request while the master's own slot is full or in flight is ignored (protocol violation; bench asserts it never happens).
- mN_busy = slot_full | inflight_N. It is combinational from registers, so it is high from T+1.
- States:
  - IDLE:
    - No slot full: t_rstrb=0, t_wmask=0.
    - Otherwise grant one slot: the only full one, or !last_grant if both are full.
    - Register t_addr/t_wdata from the slot. Write: t_wmask=slot wmask. Read: t_rstrb=1. Update last_grant.
    - Write: slot cleared at the same edge; state stays IDLE (one target cycle, posted).
    - Read: slot cleared, inflight_N set, state ISSUED.
  - ISSUED (first cycle target sees t_rstrb): t_rstrb<=0, t_wmask<=0; state WAIT.
  - WAIT:
    - t_rbusy=1: hold.
    - t_rbusy=0: mN_rdata<=t_rdata, inflight_N<=0, state IDLE.
- Latency, uncontested:
  - Read at T: t_rstrb high T+1; RAM data sampled T+2; busy low with data T+3.
  - Write at T: t_wmask high T+1; busy low T+2.
- Throughput: one write per 1 arbiter cycle after IDLE entry; one read per 3+ cycles; no back-to-back issue without passing through IDLE.
- A slot may capture a new request in the same edge it is cleared only if busy was already low to that master, which never happens by construction. Slot capture is gated by !slot_full & !inflight.
- t_addr/t_wdata hold their last value when idle; target selects only on strobes.
- Starvation-free: a pending master is granted within one other transaction.

Decomposition:
- Package mem_arb_pkg:
  - State enum localparams IDLE=2'd0, ISSUED=2'd1, WAIT=2'd2.
  - Master index localparams M0=1'b0, M1=1'b1.
- Sub-module mem_arb_slot, instantiated twice: holds capture/clear logic and addr/wdata/wmask/is_write registers, and drives full.
- Grant, FSM and target drive stay in the top.

Test Plan:
- M0 read of 0x0000_0010 alone; RAM model returns 0xDEADBEEF with t_rbusy=0 → t_rstrb pulse at T+1 with t_addr=0x10; m0_busy high T+1..T+2, low T+3 with m0_rdata=0xDEADBEEF; m1_busy stays 0.
- M0 read and M1 write (addr 0x0040_0004, wdata 0x41, wmask 4'b0001) same cycle after reset, M0_FIRST=1 → M0 read issued first; M1 t_wmask=4'b0001 pulse after M0 completes; m1_busy low one cycle later.
- Both masters continuously re-issue reads for 8 transactions → grants strictly alternate M0,M1,M0,…; no master waits more than one transaction.
- SPI-flash-like target holds t_rbusy=1 for 40 cycles after M1 read of 0x0080_0000 → m1_rdata captured only on the first t_rbusy=0 cycle; an M0 write arriving meanwhile issues only after M1 completes.
- resetn low for one cycle while in WAIT with both slots full → next cycle all busy=0, t_rstrb=0, t_wmask=0; the late t_rbusy fall delivers nothing.
- M0 asserts rstrb=1 and wmask=4'b1111 together with wdata 0x12345678 → a single write is issued: t_wmask=4'b1111, no t_rstrb pulse, m0_rdata unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared states, master indices and request decode for the memory bus arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // A master asks for service with a read strobe or any nonzero byte mask
    function automatic logic is_request(input logic rstrb, input logic [3:0] wmask);
        return rstrb | (|wmask);
    endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// rtl/mem_arb_slot.sv - single-entry pending request holder for one master
module mem_arb_slot
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rstrb,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wmask,
    input  logic              inflight,
    input  logic              clear,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    output logic [3:0]        wmask,
    output logic              is_write
);

    // Capture a request only when this master has nothing pending or in flight;
    // a strobe combined with a byte mask is treated purely as a write
    always_ff @(posedge clk) begin
        if (!resetn) begin
            full     <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            wmask    <= '0;
            is_write <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (!full && !inflight && is_request(req_rstrb, req_wmask)) begin
            full     <= 1'b1;
            addr     <= req_addr;
            wdata    <= req_wdata;
            wmask    <= req_wmask;
            is_write <= |req_wmask;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter onto one rstrb/rbusy/wmask memory target
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit M0_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rstrb,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic [31:0]       m0_rdata,
    output logic              m0_busy,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rstrb,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic [31:0]       m1_rdata,
    output logic              m1_busy,
    output logic [ADDR_W-1:0] t_addr,
    output logic              t_rstrb,
    output logic [31:0]       t_wdata,
    output logic [3:0]        t_wmask,
    input  logic [31:0]       t_rdata,
    input  logic              t_rbusy
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              last_grant;
    logic              cur;
    logic [1:0]        inflight;
    logic              grant_valid;
    logic              grant_idx;
    logic [1:0]        slot_clear;
    logic [1:0]        slot_full;
    logic [1:0]        slot_is_write;
    logic [ADDR_W-1:0] slot_addr  [2];
    logic [31:0]       slot_wdata [2];
    logic [3:0]        slot_wmask [2];

    mem_arb_slot #(.ADDR_W(ADDR_W)) u_slot0 (
        .clk       (clk),
        .resetn    (resetn),
        .req_addr  (m0_addr),
        .req_rstrb (m0_rstrb),
        .req_wdata (m0_wdata),
        .req_wmask (m0_wmask),
        .inflight  (inflight[0]),
        .clear     (slot_clear[0]),
        .full      (slot_full[0]),
        .addr      (slot_addr[0]),
        .wdata     (slot_wdata[0]),
        .wmask     (slot_wmask[0]),
        .is_write  (slot_is_write[0])
    );

    mem_arb_slot #(.ADDR_W(ADDR_W)) u_slot1 (
        .clk       (clk),
        .resetn    (resetn),
        .req_addr  (m1_addr),
        .req_rstrb (m1_rstrb),
        .req_wdata (m1_wdata),
        .req_wmask (m1_wmask),
        .inflight  (inflight[1]),
        .clear     (slot_clear[1]),
        .full      (slot_full[1]),
        .addr      (slot_addr[1]),
        .wdata     (slot_wdata[1]),
        .wmask     (slot_wmask[1]),
        .is_write  (slot_is_write[1])
    );

    assign m0_busy = slot_full[0] | inflight[0];
    assign m1_busy = slot_full[1] | inflight[1];

    // Grant selection and next state: only IDLE issues; writes are posted and stay in IDLE
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_idx   = M0;
        slot_clear  = 2'b00;
        case (state)
            IDLE: begin
                if (|slot_full) begin
                    grant_valid = 1'b1;
                    if (&slot_full) begin
                        grant_idx = ~last_grant;
                    end else begin
                        grant_idx = slot_full[1] ? M1 : M0;
                    end
                    slot_clear[grant_idx] = 1'b1;
                    if (!slot_is_write[grant_idx]) begin
                        state_next = ISSUED;
                    end
                end
            end
            ISSUED: state_next = WAIT;
            WAIT: begin
                if (!t_rbusy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Target drive, round-robin history, in-flight tracking and read data return
    always_ff @(posedge clk) begin
        if (!resetn) begin
            t_addr     <= '0;
            t_wdata    <= '0;
            t_rstrb    <= 1'b0;
            t_wmask    <= '0;
            last_grant <= M0_FIRST ? M1 : M0;
            cur        <= M0;
            inflight   <= 2'b00;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            t_rstrb <= 1'b0;
            t_wmask <= '0;
            if (grant_valid) begin
                t_addr     <= slot_addr[grant_idx];
                t_wdata    <= slot_wdata[grant_idx];
                last_grant <= grant_idx;
                if (slot_is_write[grant_idx]) begin
                    t_wmask <= slot_wmask[grant_idx];
                end else begin
                    t_rstrb             <= 1'b1;
                    inflight[grant_idx] <= 1'b1;
                    cur                 <= grant_idx;
                end
            end
            if (state == WAIT && !t_rbusy) begin
                inflight[cur] <= 1'b0;
                if (cur == M1) begin
                    m1_rdata <= t_rdata;
                end else begin
                    m0_rdata <= t_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_busy, m1_busy;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic        t_rstrb;
    logic [3:0]  t_wmask;
    logic        t_rbusy = 1'b0;
    logic [31:0] data_q = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .M0_FIRST(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_rdata(m0_rdata), .m0_busy(m0_busy),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_rdata(m1_rdata), .m1_busy(m1_busy),
        .t_addr(t_addr), .t_rstrb(t_rstrb), .t_wdata(t_wdata), .t_wmask(t_wmask),
        .t_rdata(t_rdata), .t_rbusy(t_rbusy)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Target model: latches the word on the strobe edge, drives junk while busy
    always @(posedge clk) if (t_rstrb) data_q <= ram_word(t_addr);
    assign t_rdata = t_rbusy ? 32'hBAD0_BAD0 : data_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        m0_rstrb = 1'b0; m1_rstrb = 1'b0; m0_wmask = '0; m1_wmask = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        total++;
        if ({m0_busy, m1_busy, t_rstrb, t_wmask} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0", {m0_busy, m1_busy, t_rstrb, t_wmask});
        end
        total++;
        if ({t_addr, t_wdata, m0_rdata, m1_rdata} !== 128'b0) begin
            bad++; $display("FAIL reset_data: got %h %h %h %h want 0", t_addr, t_wdata, m0_rdata, m1_rdata);
        end
        resetn = 1'b1;
    endtask

    task automatic test_uncontested_read();
        apply_reset();
        t_rbusy = 1'b0;
        m0_addr = 32'h0000_0010; m0_rstrb = 1'b1;
        step();
        m0_rstrb = 1'b0;
        total++;
        if (m0_busy !== 1'b1 || t_rstrb !== 1'b0) begin
            bad++; $display("FAIL rd_capture: busy=%b rstrb=%b want 1 0", m0_busy, t_rstrb);
        end
        step();
        total++;
        if (t_rstrb !== 1'b1 || t_addr !== 32'h10) begin
            bad++; $display("FAIL rd_issue: rstrb=%b addr=%h want 1 00000010", t_rstrb, t_addr);
        end
        step();
        total++;
        if (t_rstrb !== 1'b0 || m0_busy !== 1'b1) begin
            bad++; $display("FAIL rd_pulse: rstrb=%b busy=%b want 0 1", t_rstrb, m0_busy);
        end
        step();
        total++;
        if (m0_busy !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF || m1_busy !== 1'b0) begin
            bad++; $display("FAIL rd_done: busy=%b rdata=%h m1_busy=%b want 0 deadbeef 0", m0_busy, m0_rdata, m1_busy);
        end
    endtask

    task automatic test_contested();
        apply_reset();
        t_rbusy = 1'b0;
        m0_addr = 32'h0000_0020; m0_rstrb = 1'b1;
        m1_addr = 32'h0040_0004; m1_wdata = 32'h41; m1_wmask = 4'b0001;
        step();
        m0_rstrb = 1'b0; m1_wmask = 4'b0000;
        total++;
        if ({m0_busy, m1_busy} !== 2'b11) begin
            bad++; $display("FAIL ct_capture: got %b want 11", {m0_busy, m1_busy});
        end
        step();
        total++;
        if (t_rstrb !== 1'b1 || t_addr !== 32'h20 || t_wmask !== 4'b0) begin
            bad++; $display("FAIL ct_m0_first: rstrb=%b addr=%h wmask=%b want 1 00000020 0000", t_rstrb, t_addr, t_wmask);
        end
        step();
        step();
        total++;
        if (m0_busy !== 1'b0 || m0_rdata !== 32'h0020_FFDF || m1_busy !== 1'b1 || t_wmask !== 4'b0) begin
            bad++; $display("FAIL ct_m0_done: busy=%b rdata=%h m1_busy=%b wmask=%b", m0_busy, m0_rdata, m1_busy, t_wmask);
        end
        step();
        total++;
        if (t_wmask !== 4'b0001 || t_addr !== 32'h0040_0004 || t_wdata !== 32'h41 || m1_busy !== 1'b0 || t_rstrb !== 1'b0) begin
            bad++; $display("FAIL ct_m1_write: wmask=%b addr=%h wdata=%h busy=%b", t_wmask, t_addr, t_wdata, m1_busy);
        end
        step();
        total++;
        if (t_wmask !== 4'b0) begin
            bad++; $display("FAIL ct_wmask_pulse: got %b want 0000", t_wmask);
        end
    endtask

    task automatic test_back_to_back();
        int n0, n1, ng, cyc;
        logic [31:0] a0, a1;
        logic p0, p1;
        logic [7:0] order;
        n0 = 0; n1 = 0; ng = 0; cyc = 0; a0 = '0; a1 = '0; p0 = 1'b0; p1 = 1'b0; order = '0;
        apply_reset();
        t_rbusy = 1'b0;
        while ((ng < 8 || m0_busy || m1_busy || m0_rstrb || m1_rstrb) && cyc < 300) begin
            if (t_rstrb) begin
                if (ng < 8) order[ng] = t_addr[9];
                ng++;
            end
            if (p0 && !m0_busy) begin
                total++;
                if (m0_rdata !== ram_word(a0)) begin
                    bad++; $display("FAIL b2b_m0_data: got %h want %h", m0_rdata, ram_word(a0));
                end
            end
            if (p1 && !m1_busy) begin
                total++;
                if (m1_rdata !== ram_word(a1)) begin
                    bad++; $display("FAIL b2b_m1_data: got %h want %h", m1_rdata, ram_word(a1));
                end
            end
            p0 = m0_busy; p1 = m1_busy;
            if (!m0_busy && !m0_rstrb && n0 < 4) begin
                a0 = 32'h100 + 32'(n0 * 4); m0_addr = a0; m0_rstrb = 1'b1; n0++;
            end else begin
                m0_rstrb = 1'b0;
            end
            if (!m1_busy && !m1_rstrb && n1 < 4) begin
                a1 = 32'h200 + 32'(n1 * 4); m1_addr = a1; m1_rstrb = 1'b1; n1++;
            end else begin
                m1_rstrb = 1'b0;
            end
            step();
            cyc++;
        end
        m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        total++;
        if (ng !== 8) begin
            bad++; $display("FAIL b2b_grant_count: got %0d want 8 (cycles %0d)", ng, cyc);
        end
        for (int i = 0; i < 8; i++) begin
            logic want;
            want = (i % 2 == 1);
            total++;
            if (order[i] !== want) begin
                bad++; $display("FAIL b2b_order[%0d]: got M%0d want M%0d", i, order[i], want);
            end
        end
    endtask

    task automatic test_slow_target();
        int errs;
        errs = 0;
        apply_reset();
        t_rbusy = 1'b1;
        m1_addr = 32'h0080_0000; m1_rstrb = 1'b1;
        step();
        m1_rstrb = 1'b0;
        step();
        total++;
        if (t_rstrb !== 1'b1 || t_addr !== 32'h0080_0000) begin
            bad++; $display("FAIL slow_issue: rstrb=%b addr=%h want 1 00800000", t_rstrb, t_addr);
        end
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin
                m0_addr = 32'h30; m0_wdata = 32'hCAFE_F00D; m0_wmask = 4'b0011;
            end
            if (i == 3) m0_wmask = 4'b0000;
            step();
            if (t_rstrb !== 1'b0 || t_wmask !== 4'b0 || m1_busy !== 1'b1) errs++;
            if (i >= 2 && m0_busy !== 1'b1) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL slow_hold: %0d bad cycles, want 0", errs);
        end
        t_rbusy = 1'b0;
        step();
        total++;
        if (m1_busy !== 1'b0 || m1_rdata !== 32'h0000_FFFF || t_wmask !== 4'b0 || m0_busy !== 1'b1) begin
            bad++; $display("FAIL slow_done: busy=%b rdata=%h wmask=%b m0_busy=%b", m1_busy, m1_rdata, t_wmask, m0_busy);
        end
        step();
        total++;
        if (t_wmask !== 4'b0011 || t_addr !== 32'h30 || t_wdata !== 32'hCAFE_F00D || m0_busy !== 1'b0) begin
            bad++; $display("FAIL slow_m0_write: wmask=%b addr=%h wdata=%h busy=%b", t_wmask, t_addr, t_wdata, m0_busy);
        end
    endtask

    task automatic test_reset_mid();
        int errs;
        errs = 0;
        apply_reset();
        t_rbusy = 1'b1;
        m0_addr = 32'h50; m0_rstrb = 1'b1;
        m1_addr = 32'h60; m1_rstrb = 1'b1;
        step();
        m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        step();
        step();
        step();
        total++;
        if ({m0_busy, m1_busy} !== 2'b11) begin
            bad++; $display("FAIL rm_pre: got %b want 11", {m0_busy, m1_busy});
        end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        total++;
        if ({m0_busy, m1_busy, t_rstrb, t_wmask} !== 7'b0 || t_addr !== 32'h0) begin
            bad++; $display("FAIL rm_after: ctrl=%b addr=%h want 0", {m0_busy, m1_busy, t_rstrb, t_wmask}, t_addr);
        end
        t_rbusy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if ({m0_busy, m1_busy, t_rstrb, t_wmask} !== 7'b0) errs++;
        end
        total++;
        if (errs !== 0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            bad++; $display("FAIL rm_no_delivery: errs=%0d m0=%h m1=%h want 0", errs, m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_read_write_combo();
        int errs;
        errs = 0;
        apply_reset();
        t_rbusy = 1'b0;
        m0_addr = 32'h10; m0_rstrb = 1'b1;
        step();
        m0_rstrb = 1'b0;
        step(); step(); step();
        total++;
        if (m0_rdata !== 32'hDEAD_BEEF || m0_busy !== 1'b0) begin
            bad++; $display("FAIL combo_setup: rdata=%h busy=%b want deadbeef 0", m0_rdata, m0_busy);
        end
        m0_addr = 32'h44; m0_wdata = 32'h1234_5678; m0_rstrb = 1'b1; m0_wmask = 4'b1111;
        step();
        m0_rstrb = 1'b0; m0_wmask = 4'b0000;
        total++;
        if (m0_busy !== 1'b1) begin
            bad++; $display("FAIL combo_capture: busy=%b want 1", m0_busy);
        end
        step();
        total++;
        if (t_wmask !== 4'b1111 || t_rstrb !== 1'b0 || t_addr !== 32'h44 || t_wdata !== 32'h1234_5678 || m0_busy !== 1'b0) begin
            bad++; $display("FAIL combo_write: wmask=%b rstrb=%b addr=%h wdata=%h busy=%b", t_wmask, t_rstrb, t_addr, t_wdata, m0_busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (t_rstrb !== 1'b0 || t_wmask !== 4'b0 || m0_busy !== 1'b0) errs++;
        end
        total++;
        if (errs !== 0 || m0_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL combo_no_read: errs=%0d rdata=%h want 0 deadbeef", errs, m0_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_uncontested_read();
        test_contested();
        test_back_to_back();
        test_slow_target();
        test_reset_mid();
        test_read_write_combo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
